// File: rtl/alu_cmd_driver_if.sv
// ALU opcode package and the stream/ALU bundle used by alu_cmd_driver.
// The slave modport is the driver's view; master is the source, consumer and ALU side.
package ALU_pkg;
  typedef enum logic [3:0] {
    Add             = 4'd0,
    Sub             = 4'd1,
    LeftShift       = 4'd2,
    RightShiftArith = 4'd3,
    RightShiftLogic = 4'd4,
    And             = 4'd5,
    Or              = 4'd6,
    Xor             = 4'd7,
    Equal           = 4'd8
  } OpCode;
endpackage

interface alu_cmd_if;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [19:0]       cmd_data;
  logic [7:0]        alu_a;
  logic [7:0]        alu_b;
  ALU_pkg::OpCode    alu_op;
  logic [7:0]        alu_out;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_data;
  logic              rsp_err;

  modport slave (
    input  cmd_valid, cmd_data, alu_out, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output cmd_valid, cmd_data, alu_out, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_cmd_driver.sv
// Buffers packed ALU commands in a FIFO, issues them one at a time to the
// combinational ALU and returns each registered result on a response stream.
module alu_cmd_driver #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  alu_cmd_if.slave    bus,
  output logic        busy,
  output logic [15:0] done_cnt
);
  import ALU_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t      state;
  state_t      state_next;
  logic [19:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic [19:0] head;
  logic [3:0]  head_op;
  logic        illegal;
  logic [7:0]  rsp_data_q;
  logic        rsp_err_q;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty   = (wr_ptr == rd_ptr);
  assign push    = bus.cmd_valid && !full;
  assign pop     = (state == ISSUE);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign head_op = head[19:16];
  assign illegal = (head_op > 4'd8);

  assign bus.cmd_ready = !full;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = !empty || (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= bus.cmd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // RESP looks ahead to a same-edge push so back-to-back commands need no IDLE gap.
  always_comb begin
    state_next = state;
    bus.alu_a  = '0;
    bus.alu_b  = '0;
    bus.alu_op = Add;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        bus.alu_a  = head[15:8];
        bus.alu_b  = head[7:0];
        bus.alu_op = illegal ? Add : OpCode'(head_op);
        state_next = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_next = (!empty || push) ? ISSUE : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      done_cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == ISSUE) begin
        rsp_data_q <= illegal ? 8'h00 : bus.alu_out;
        rsp_err_q  <= illegal;
      end
      if ((state == RESP) && bus.rsp_ready) begin
        done_cnt <= done_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Self-checking bench for alu_cmd_driver: models the ALU, keeps a queue of
// expected responses derived from accepted commands, and runs directed plus random traffic.
module tb_alu_cmd_driver;
  import ALU_pkg::*;

  logic        clk;
  logic        rst;
  logic        busy;
  logic [15:0] done_cnt;

  alu_cmd_if bus ();

  alu_cmd_driver #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .done_cnt (done_cnt)
  );

  int checkCount = 0;
  int errorCount = 0;

  logic [8:0]  expQ [$];
  logic [7:0]  obsLog [$];
  logic [15:0] modelDone;
  logic        heldPrev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 8-bit ALU; also serves as the reference for legal opcodes.
  function automatic logic [7:0] aluRef(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a << b;
      4'd3:    r = $signed(a) >>> b;
      4'd4:    r = a >> b;
      4'd5:    r = a & b;
      4'd6:    r = a | b;
      4'd7:    r = a ^ b;
      4'd8:    r = (a == b) ? 8'h01 : 8'h00;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [8:0] refResponse(input logic [19:0] cmd);
    logic [3:0] op;
    op = cmd[19:16];
    if (op > 4'd8) return {1'b1, 8'h00};
    return {1'b0, aluRef(op, cmd[15:8], cmd[7:0])};
  endfunction

  always_comb bus.alu_out = aluRef(bus.alu_op, bus.alu_a, bus.alu_b);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic accepted;
    accepted = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = {op, a, b};
    for (int n = 0; n < 50 && !accepted; n++) begin
      if (bus.cmd_ready) accepted = 1'b1;
      tick();
    end
    bus.cmd_valid = 1'b0;
    checkOutput("cmd_accept", 32'(accepted), 32'd1);
  endtask

  task automatic waitIdle();
    for (int n = 0; n < 200 && busy; n++) tick();
    checkOutput("drain_busy", 32'(busy), 32'd0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
  endtask

  // Scoreboard: responses are compared against the queue of accepted commands.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst) begin
      expQ.delete();
      modelDone = '0;
      heldPrev  = 1'b0;
    end else begin
      checkOutput("done_cnt", 32'(done_cnt), 32'(modelDone));
      if (heldPrev) checkOutput("rsp_valid_hold", 32'(bus.rsp_valid), 32'd1);
      if (bus.rsp_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
        end else begin
          e = expQ[0];
          checkOutput("rsp_data", 32'(bus.rsp_data), 32'(e[7:0]));
          checkOutput("rsp_err", 32'(bus.rsp_err), 32'(e[8]));
          if (bus.rsp_ready) begin
            void'(expQ.pop_front());
            obsLog.push_back(bus.rsp_data);
            modelDone = modelDone + 16'd1;
          end
        end
      end
      heldPrev = bus.rsp_valid && !bus.rsp_ready;
      if (bus.cmd_valid && bus.cmd_ready) expQ.push_back(refResponse(bus.cmd_data));
    end
  end

  initial begin
    logic [7:0] seq2 [10];
    logic [7:0] e8;
    seq2 = '{8'hF4, 8'hEC, 8'h00, 8'hFF, 8'h0F, 8'h00, 8'hF4, 8'hF4, 8'h00, 8'h01};
    bus.cmd_data = '0;

    // Reset values
    doReset();
    checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    checkOutput("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    checkOutput("rst_alu_a", 32'(bus.alu_a), 32'd0);
    checkOutput("rst_alu_b", 32'(bus.alu_b), 32'd0);
    checkOutput("rst_alu_op", 32'(bus.alu_op), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done_cnt", 32'(done_cnt), 32'd0);
    rst = 1'b0;

    // Single command latency
    $display("[TB] single command");
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = {4'd0, 8'h7F, 8'h01};
    tick();
    bus.cmd_valid = 1'b0;
    checkOutput("t1_idle_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    tick();
    checkOutput("t1_issue_a", 32'(bus.alu_a), 32'h7F);
    checkOutput("t1_issue_b", 32'(bus.alu_b), 32'h01);
    checkOutput("t1_issue_op", 32'(bus.alu_op), 32'd0);
    checkOutput("t1_issue_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    checkOutput("t1_resp_valid", 32'(bus.rsp_valid), 32'd1);
    checkOutput("t1_resp_data", 32'(bus.rsp_data), 32'h80);
    checkOutput("t1_resp_err", 32'(bus.rsp_err), 32'd0);
    checkOutput("t1_resp_alu_a", 32'(bus.alu_a), 32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    checkOutput("t1_done_cnt", 32'(done_cnt), 32'd1);
    checkOutput("t1_after_valid", 32'(bus.rsp_valid), 32'd0);

    // All legal opcodes
    $display("[TB] opcode sweep");
    waitIdle();
    obsLog.delete();
    for (int op = 0; op < 9; op++) applyStimulus(4'(op), 8'hF0, 8'h04);
    applyStimulus(4'd8, 8'h33, 8'h33);
    waitIdle();
    checkOutput("t2_count", 32'(obsLog.size()), 32'd10);
    for (int k = 0; k < 10 && k < obsLog.size(); k++)
      checkOutput($sformatf("t2_result_%0d", k), 32'(obsLog[k]), 32'(seq2[k]));

    // Illegal opcode
    $display("[TB] illegal opcode");
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = {4'hC, 8'h12, 8'h34};
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    checkOutput("t3_issue_op", 32'(bus.alu_op), 32'd0);
    checkOutput("t3_issue_a", 32'(bus.alu_a), 32'h12);
    checkOutput("t3_issue_b", 32'(bus.alu_b), 32'h34);
    tick();
    checkOutput("t3_err", 32'(bus.rsp_err), 32'd1);
    checkOutput("t3_data", 32'(bus.rsp_data), 32'd0);
    applyStimulus(4'd7, 8'h55, 8'h0F);
    waitIdle();
    checkOutput("t3_next_err", 32'(bus.rsp_err), 32'd0);
    checkOutput("t3_next_data", 32'(bus.rsp_data), 32'h5A);

    // Backpressure and full
    $display("[TB] backpressure");
    doReset();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) applyStimulus(4'($urandom_range(0, 8)), 8'($urandom), 8'($urandom));
    checkOutput("t4_full_ready", 32'(bus.cmd_ready), 32'd0);
    checkOutput("t4_held_valid", 32'(bus.rsp_valid), 32'd1);
    for (int k = 0; k < 5; k++) tick();
    checkOutput("t4_still_full", 32'(bus.cmd_ready), 32'd0);
    bus.rsp_ready = 1'b1;
    waitIdle();
    checkOutput("t4_done_cnt", 32'(done_cnt), 32'd5);
    checkOutput("t4_busy", 32'(busy), 32'd0);

    // Streaming with pointer wrap
    $display("[TB] streaming");
    obsLog.delete();
    for (int i = 0; i < 20; i++) applyStimulus(4'd1, 8'(i), 8'h01);
    waitIdle();
    checkOutput("t5_count", 32'(obsLog.size()), 32'd20);
    for (int i = 0; i < 20 && i < obsLog.size(); i++) begin
      e8 = 8'(i) - 8'd1;
      checkOutput($sformatf("t5_result_%0d", i), 32'(obsLog[i]), 32'(e8));
    end

    // Random traffic with random backpressure
    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd_data  = 20'($urandom);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    waitIdle();
    checkOutput("rand_pending", 32'(expQ.size()), 32'd0);

    // Reset mid-operation
    $display("[TB] reset mid-operation");
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) applyStimulus(4'd0, 8'(k), 8'h10);
    checkOutput("t6_in_resp", 32'(bus.rsp_valid), 32'd1);
    rst = 1'b1;
    tick();
    checkOutput("t6_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_done_cnt", 32'(done_cnt), 32'd0);
    checkOutput("t6_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    checkOutput("t6_rsp_data", 32'(bus.rsp_data), 32'd0);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    checkOutput("t6_no_stale", 32'(bus.rsp_valid), 32'd0);
    checkOutput("t6_idle_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Requester-side front end for the 8-bit combinational ALU. Accepts packed command words over a valid/ready stream and buffers them in a small FIFO. Issues one command at a time to the ALU's `A`/`B`/`op` inputs, registers the ALU `out`, and returns it on a valid/ready response stream with an illegal-opcode flag. It sits between the instruction/test source and the ALU instance.

## Interface
Parameters:
- `DEPTH`, default 4: command FIFO entries; must be a power of 2 and at least 2.

Ports:
- `clk`, input, 1: the single clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `cmd_valid`, input, 1: command word present.
- `cmd_ready`, output, 1: FIFO can accept; equals `!full`.
- `cmd_data`, input, 20: packed command; [19:16] = opcode, [15:8] = A, [7:0] = B.
- `alu_a`, output, 8: drives ALU `A`.
- `alu_b`, output, 8: drives ALU `B`.
- `alu_op`, output, `ALU_pkg::OpCode`: drives ALU `op`.
- `alu_out`, input, 8: ALU result; combinational from `alu_a`/`alu_b`/`alu_op`.
- `rsp_valid`, output, 1: response present.
- `rsp_ready`, input, 1: consumer accepts the response.
- `rsp_data`, output, 8: registered result.
- `rsp_err`, output, 1: the command opcode was greater than 8.
- `busy`, output, 1: FIFO is non-empty or the FSM is not IDLE.
- `done_cnt`, output, 16: number of completed responses; wraps.

## Operation
Opcode encoding, fixed: Add=0, Sub=1, LeftShift=2, RightShiftArith=3, RightShiftLogic=4, And=5, Or=6, Xor=7, Equal=8.

Opcodes 9–15 are illegal:
- `alu_op` is driven as Add.
- The captured `rsp_data` is forced to 0.
- `rsp_err` is 1.

FIFO:
- Write when `cmd_valid && cmd_ready`.
- Read (pop) on the cycle the FSM leaves ISSUE.
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH.
- Full when the low bits are equal and the MSB differs; empty when the pointers are equal.
- Simultaneous push and pop when full is not possible, because `cmd_ready` is 0.
- Simultaneous push and pop at any other occupancy: the count is unchanged.
- Write while empty: data is visible at the head on the next cycle, with no bypass.

FSM states: IDLE, ISSUE, RESP.

IDLE:
- `alu_a`, `alu_b`, `alu_op` = 0/0/Add.
- Go to ISSUE when the FIFO is non-empty.

ISSUE (exactly one cycle):
- Drive the ALU inputs from the FIFO head.
- At the clock edge, capture `alu_out` (or 0 if illegal) into `rsp_data`, set `rsp_err`, pop the FIFO, and go to RESP.

RESP:
- `rsp_valid` = 1; `rsp_data`/`rsp_err` are stable until accepted.
- ALU inputs return to 0/0/Add.
- When `rsp_ready`: `done_cnt`++, then go to ISSUE if the FIFO will be non-empty in the next cycle, else IDLE.
- "Non-empty in the next cycle" means the occupancy after this edge, including a push on the same edge.

Other rules:
- `rsp_valid` never drops without `rsp_ready`.
- `rsp_valid` is 0 in IDLE and ISSUE.
- Arithmetic is done entirely in the ALU at 8 bits; the driver performs no width extension.

## Timing
Reset values:
- FSM = IDLE; FIFO empty.
- `cmd_ready` = 1; `rsp_valid` = 0; `rsp_data` = 0; `rsp_err` = 0.
- `alu_a`/`alu_b` = 0; `alu_op` = Add.
- `busy` = 0; `done_cnt` = 0.

Latency:
- A command accepted at edge N into an empty FIFO with the FSM in IDLE: ISSUE during cycle N+1, `rsp_valid` high from cycle N+2.
- Back-to-back throughput is one response per 2 cycles when `rsp_ready` is held at 1 (RESP → ISSUE → RESP).

`done_cnt` updates on the same edge as the response handshake.

Reset mid-operation: reset asserted during ISSUE or RESP drops the in-flight command and all FIFO contents. All outputs show reset values in the cycle after the reset edge.

`cmd_ready` is combinational from the FIFO state only; it does not depend on `rsp_ready`.

## Test plan
1. Single command: after reset, send cmd op=0, A=0x7F, B=0x01 → `rsp_valid` 2 cycles later with `rsp_data`=0x80, `rsp_err`=0, `done_cnt`=1.
2. All legal opcodes with A=0xF0, B=0x04 and `rsp_ready`=1 → results in order: 0xF4, 0xEC, 0x00, 0xFF, 0x0F, 0x00, 0xF4, 0xF4, 0x00. Then Equal with A=B=0x33 → 0x01.
3. Illegal opcode 0xC with A=0x12, B=0x34 → `rsp_data`=0x00, `rsp_err`=1, `alu_op`=Add during ISSUE; the next legal command returns `rsp_err`=0.
4. Backpressure and full: hold `rsp_ready`=0 and push 5 commands with DEPTH=4. The first command is issued and held; the next 4 fill the FIFO, then `cmd_ready`=0. `rsp_data` is stable throughout. After releasing `rsp_ready`, all 5 responses come out in order, with `done_cnt`=5 and `busy`=0 at the end.
5. Simultaneous push/pop and pointer wrap: stream 20 commands (op=1, A=i, B=1) with `cmd_valid` and `rsp_ready` both at 1. The responses are i−1 in order (i=0 gives 0xFF), with no drops or duplicates.
6. Reset mid-operation: assert `rst` while in RESP with 2 entries queued → next cycle `rsp_valid`=0, `busy`=0, `done_cnt`=0, and no stale response after reset is released.
